prom16_loader: RTL and testbench

- Write-side sequencer for prom16_8bit. Drives the memory's load interface (data_in, addr, low_load, low_o_en).
- Accepts a stream of 16 program bytes over a valid/ready handshake and writes them to addresses 0..15 in order.
- Keeps a running 8-bit checksum of the written bytes. Can optionally read the memory back and check the contents.
- Sits between the program source (switch bank or serial front end) and the SAP program memory. The CPU controller holds the core off until done.

---
 rtl/prom16_loader.sv | 221 ++++++++++++++++++++++
 tb/tb_prom16_loader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/prom16_loader.sv
// prom16_loader: accepts 16 program bytes over valid/ready and writes them to prom16_8bit addresses 0..15.
// Define PROM16_LOADER_VERIFY_EN to add a read-back pass that compares the memory sum against the checksum.
module prom16_loader #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          start,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] mem_data_in,
    output logic [AW-1:0] mem_addr,
    output logic          mem_low_load,
    output logic          mem_low_o_en,
    input  logic [DW-1:0] mem_data_out,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] checksum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BYTE,
        S_WRITE,
        S_DONE
`ifdef PROM16_LOADER_VERIFY_EN
        , S_VERIFY
`endif
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t        r_state, w_state_next;
    logic [AW-1:0] r_index, w_index_next;
    logic          r_in_ready, w_in_ready_next;
    logic [DW-1:0] r_mem_data_in, w_mem_data_in_next;
    logic [AW-1:0] r_mem_addr, w_mem_addr_next;
    logic          r_low_load, w_low_load_next;
    logic          r_busy, w_busy_next;
    logic          r_done, w_done_next;
    logic [DW-1:0] r_checksum, w_checksum_next;
    logic          w_accept;
    logic          w_last_index;

`ifdef PROM16_LOADER_VERIFY_EN
    logic          r_low_o_en, w_low_o_en_next;
    logic          r_err, w_err_next;
    logic [DW-1:0] r_rb_sum, w_rb_sum_next;
    logic [DW-1:0] w_rb_sum_final;

    assign w_rb_sum_final = r_rb_sum + mem_data_out;
`endif

    assign w_accept     = (r_state == S_WAIT_BYTE) && in_valid && r_in_ready;
    assign w_last_index = (r_index == LAST);

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (start) w_state_next = S_WAIT_BYTE;
            end
            S_WAIT_BYTE: begin
                if (w_accept) w_state_next = S_WRITE;
            end
            S_WRITE: begin
                if (w_last_index) begin
`ifdef PROM16_LOADER_VERIFY_EN
                    w_state_next = S_VERIFY;
`else
                    w_state_next = S_DONE;
`endif
                end else begin
                    w_state_next = S_WAIT_BYTE;
                end
            end
`ifdef PROM16_LOADER_VERIFY_EN
            S_VERIFY: begin
                if (r_mem_addr == LAST) w_state_next = S_DONE;
            end
`endif
            default: w_state_next = S_IDLE;
        endcase
    end

    // Next values for every registered output; outputs only change on state events.
    always_comb begin
        w_index_next       = r_index;
        w_in_ready_next    = r_in_ready;
        w_mem_data_in_next = r_mem_data_in;
        w_mem_addr_next    = r_mem_addr;
        w_low_load_next    = r_low_load;
        w_busy_next        = r_busy;
        w_done_next        = r_done;
        w_checksum_next    = r_checksum;
`ifdef PROM16_LOADER_VERIFY_EN
        w_low_o_en_next    = r_low_o_en;
        w_err_next         = r_err;
        w_rb_sum_next      = r_rb_sum;
`endif
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_index_next    = '0;
                    w_checksum_next = '0;
                    w_done_next     = 1'b0;
                    w_busy_next     = 1'b1;
                    w_in_ready_next = 1'b1;
                    w_mem_addr_next = '0;
`ifdef PROM16_LOADER_VERIFY_EN
                    w_err_next      = 1'b0;
`endif
                end
            end
            S_WAIT_BYTE: begin
                if (w_accept) begin
                    w_mem_data_in_next = in_data;
                    w_mem_addr_next    = r_index;
                    w_checksum_next    = r_checksum + in_data;
                    w_in_ready_next    = 1'b0;
                    w_low_load_next    = 1'b0;
                end
            end
            S_WRITE: begin
                w_low_load_next = 1'b1;
                if (w_last_index) begin
`ifdef PROM16_LOADER_VERIFY_EN
                    // Read enable asserts on the same edge the write strobe releases.
                    w_low_o_en_next = 1'b0;
                    w_mem_addr_next = '0;
                    w_rb_sum_next   = '0;
`else
                    w_done_next     = 1'b1;
                    w_busy_next     = 1'b0;
                    w_mem_addr_next = '0;
`endif
                end else begin
                    w_index_next    = r_index + 1'b1;
                    w_in_ready_next = 1'b1;
                end
            end
`ifdef PROM16_LOADER_VERIFY_EN
            S_VERIFY: begin
                w_rb_sum_next   = w_rb_sum_final;
                w_mem_addr_next = r_mem_addr + 1'b1;
                if (r_mem_addr == LAST) begin
                    w_err_next      = (w_rb_sum_final != r_checksum);
                    w_low_o_en_next = 1'b1;
                    w_done_next     = 1'b1;
                    w_busy_next     = 1'b0;
                    w_mem_addr_next = '0;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_index       <= '0;
            r_in_ready    <= 1'b0;
            r_mem_data_in <= '0;
            r_mem_addr    <= '0;
            r_low_load    <= 1'b1;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_checksum    <= '0;
`ifdef PROM16_LOADER_VERIFY_EN
            r_low_o_en    <= 1'b1;
            r_err         <= 1'b0;
            r_rb_sum      <= '0;
`endif
        end else begin
            r_index       <= w_index_next;
            r_in_ready    <= w_in_ready_next;
            r_mem_data_in <= w_mem_data_in_next;
            r_mem_addr    <= w_mem_addr_next;
            r_low_load    <= w_low_load_next;
            r_busy        <= w_busy_next;
            r_done        <= w_done_next;
            r_checksum    <= w_checksum_next;
`ifdef PROM16_LOADER_VERIFY_EN
            r_low_o_en    <= w_low_o_en_next;
            r_err         <= w_err_next;
            r_rb_sum      <= w_rb_sum_next;
`endif
        end
    end

    assign in_ready     = r_in_ready;
    assign mem_data_in  = r_mem_data_in;
    assign mem_addr     = r_mem_addr;
    assign mem_low_load = r_low_load;
    assign busy         = r_busy;
    assign done         = r_done;
    assign checksum     = r_checksum;

`ifdef PROM16_LOADER_VERIFY_EN
    assign mem_low_o_en = r_low_o_en;
    assign err          = r_err;
`else
    logic w_unused_rdata;
    assign w_unused_rdata = ^mem_data_out;
    assign mem_low_o_en   = 1'b1;
    assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_prom16_loader.sv
// Bench for prom16_loader: table-driven loads, hand-written abort/start-pulse sequences and random loads
// against a memory stand-in and a sum-of-bytes reference model.
`timescale 1ns/1ps
module tb_prom16_loader;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DW    = 8;
`ifdef PROM16_LOADER_VERIFY_EN
    localparam int VERIFY_CYC = 16;
`else
    localparam int VERIFY_CYC = 0;
`endif
    localparam int LOAD_LAT = 31 + VERIFY_CYC;

    logic          clk = 1'b0;
    logic          clr, start, in_valid, in_ready;
    logic [DW-1:0] in_data, mem_data_in, mem_data_out, checksum;
    logic [AW-1:0] mem_addr;
    logic          mem_low_load, mem_low_o_en, busy, done, err;

    always #5 clk = ~clk;

    prom16_loader #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .clr(clr), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_data_in(mem_data_in), .mem_addr(mem_addr),
        .mem_low_load(mem_low_load), .mem_low_o_en(mem_low_o_en),
        .mem_data_out(mem_data_out),
        .busy(busy), .done(done), .err(err), .checksum(checksum)
    );

    // Memory stand-in with an optional single-bit read fault at address 9.
    typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
    logic [DW-1:0] mem [DEPTH];
    wr_t           wr_q [$];
    logic          corrupt_en;
    int            cyc = 0;
    int            overlap_cnt = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!mem_low_load) begin
            mem[mem_addr] <= mem_data_in;
            wr_q.push_back('{a: mem_addr, d: mem_data_in});
        end
        if (!mem_low_load && !mem_low_o_en) overlap_cnt <= overlap_cnt + 1;
    end

    always_comb begin
        mem_data_out = 8'h00;
        if (!mem_low_o_en)
            mem_data_out = mem[mem_addr] ^ ((corrupt_en && mem_addr == 4'd9) ? 8'h01 : 8'h00);
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [7:0] model_sum(input logic [7:0] b [16]);
        int s = 0;
        for (int i = 0; i < 16; i++) s += int'(b[i]);
        return 8'(s % 256);
    endfunction

    task automatic do_start(input string tag);
        wr_q.delete();
        start = 1'b1;
        step();
        start = 1'b0;
        check({tag, "_start_busy"}, busy, 1);
        check({tag, "_start_ready"}, in_ready, 1);
        check({tag, "_start_done_clr"}, {done, err, checksum}, 0);
    endtask

    // Source that presents byte k until accepted; returns the cycle of the first acceptance.
    task automatic stream(input string tag, input logic [7:0] b [16], input int on_c, input int off_c,
                          input bit rnd, input int stop_after, input int pulse_at,
                          output int first_acc_cyc);
        int  k = 0, c = 0, budget = 0;
        bit  acc, pulsed = 1'b0;
        first_acc_cyc = -1;
        while (k < stop_after && budget < 400) begin
            in_valid = rnd ? 1'($urandom_range(0, 1)) : ((c % (on_c + off_c)) < on_c);
            in_data  = in_valid ? b[k] : 8'($urandom);
            start    = (!pulsed && pulse_at == k && in_ready);
            acc      = in_valid && in_ready;
            step();
            if (start) begin
                pulsed = 1'b1;
                check({tag, "_pulse_busy"}, busy, 1);
            end
            start = 1'b0;
            if (acc) begin
                if (k == 0) first_acc_cyc = cyc;
                k++;
            end
            c++;
            budget++;
        end
        in_valid = 1'b0;
        check({tag, "_accepted"}, k, stop_after);
    endtask

    task automatic run_load(input string tag, input logic [7:0] b [16], input int on_c, input int off_c,
                            input bit rnd, input int pulse_at, input logic [7:0] exp_sum,
                            input bit exp_err, input bit exact_lat);
        int first_acc, n = 0, bad = 0;
        do_start(tag);
        stream(tag, b, on_c, off_c, rnd, 16, pulse_at, first_acc);
        while (!done && n < 100) begin
            step();
            n++;
        end
        check({tag, "_done"}, done, 1);
        if (exact_lat) check({tag, "_latency"}, cyc - first_acc, LOAD_LAT);
        else           check({tag, "_min_latency"}, (cyc - first_acc) >= LOAD_LAT, 1);
        check({tag, "_idle_outs"}, {busy, in_ready, mem_addr, mem_low_load, mem_low_o_en}, 7'b0000011);
        check({tag, "_checksum"}, checksum, exp_sum);
        check({tag, "_err"}, err, exp_err);
        check({tag, "_nwrites"}, wr_q.size(), 16);
        for (int i = 0; i < 16; i++) begin
            if (i >= wr_q.size() || wr_q[i].a != 4'(i) || wr_q[i].d != b[i]) bad++;
            if (mem[i] !== b[i]) bad++;
        end
        check({tag, "_write_seq"}, bad, 0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            step();
        end
        in_valid = 1'b0;
        check({tag, "_hold"}, {done, checksum, 8'(wr_q.size())}, {1'b1, exp_sum, 8'd16});
    endtask

    typedef struct {
        logic [7:0] base;
        logic [7:0] stp;
        int         on_c;
        int         off_c;
        logic [7:0] exp_sum;
    } vec_t;

    vec_t       vt [4];
    logic [7:0] bv [16];
    int         dummy;

    initial begin
        vt[0] = '{8'h00, 8'h01, 1, 0, 8'h78};
        vt[1] = '{8'h11, 8'h00, 1, 2, 8'h10};
        vt[2] = '{8'hFF, 8'h00, 2, 1, 8'hF0};
        vt[3] = '{8'h80, 8'h10, 1, 1, 8'h80};

        clr = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; corrupt_en = 1'b0;
        step();
        check("reset_ctrl", {busy, done, err, in_ready}, 0);
        check("reset_strobes", {mem_low_load, mem_low_o_en}, 2'b11);
        check("reset_data", {mem_addr, mem_data_in, checksum}, 0);
        clr = 1'b0;
        step();
        check("idle_stays", {busy, done, in_ready}, 0);

        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 16; i++) bv[i] = 8'(vt[t].base + vt[t].stp * 8'(i));
            run_load($sformatf("vec%0d", t), bv, vt[t].on_c, vt[t].off_c, 1'b0, -1,
                     vt[t].exp_sum, 1'b0, vt[t].off_c == 0);
            $display("load vec%0d: checksum=%02h done=%0d err=%0d", t, checksum, done, err);
        end

        for (int i = 0; i < 16; i++) bv[i] = 8'(8'h30 + i);
        run_load("pulse7", bv, 1, 1, 1'b0, 7, model_sum(bv), 1'b0, 1'b0);
        $display("load pulse7: checksum=%02h", checksum);

        for (int i = 0; i < 16; i++) bv[i] = 8'(8'hA0 + i);
        do_start("abort");
        stream("abort", bv, 1, 0, 1'b0, 5, -1, dummy);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("abort_ctrl", {busy, done, err, in_ready}, 0);
        check("abort_strobe", mem_low_load, 1);
        check("abort_data", {mem_addr, checksum}, 0);
        check("abort_nwrites", wr_q.size(), 5);
        for (int i = 0; i < 5; i++) check($sformatf("abort_mem%0d", i), mem[i], 8'(8'hA0 + i));
        check("abort_mem5_kept", mem[5], 8'h35);
        $display("abort after 5 bytes: writes=%0d", wr_q.size());

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) bv[i] = 8'($urandom);
            run_load($sformatf("rand%0d", r), bv, 1, 1, 1'b1, -1, model_sum(bv), 1'b0, 1'b0);
            $display("load rand%0d: checksum=%02h model=%02h", r, checksum, model_sum(bv));
        end

`ifdef PROM16_LOADER_VERIFY_EN
        for (int i = 0; i < 16; i++) bv[i] = 8'(i);
        corrupt_en = 1'b1;
        run_load("vfy_bad", bv, 1, 0, 1'b0, -1, 8'h78, 1'b1, 1'b1);
        $display("verify corrupted: err=%0d", err);
        corrupt_en = 1'b0;
        run_load("vfy_good", bv, 1, 0, 1'b0, -1, 8'h78, 1'b0, 1'b1);
        $display("verify clean: err=%0d", err);
`endif

        check("strobe_overlap", overlap_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
